// File: rtl/bram_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port BRAM with
// registered read data, plus an optional zero-fill of the RAM after reset.
module bram_arbiter #(
    parameter int unsigned DATA_WIDTH     = 5,
    parameter int unsigned ADDR_WIDTH     = 10,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  A_VALID,
    output logic                  A_READY,
    input  logic                  A_WE,
    input  logic [ADDR_WIDTH-1:0] A_ADDR,
    input  logic [DATA_WIDTH-1:0] A_DIN,
    output logic                  A_RVALID,
    output logic [DATA_WIDTH-1:0] A_RDATA,
    input  logic                  B_VALID,
    output logic                  B_READY,
    input  logic                  B_WE,
    input  logic [ADDR_WIDTH-1:0] B_ADDR,
    input  logic [DATA_WIDTH-1:0] B_DIN,
    output logic                  B_RVALID,
    output logic [DATA_WIDTH-1:0] B_RDATA,
    output logic                  RAM_WE,
    output logic [ADDR_WIDTH-1:0] RAM_ADDR,
    output logic [DATA_WIDTH-1:0] RAM_DIN,
    input  logic [DATA_WIDTH-1:0] RAM_DOUT,
    output logic                  INIT_DONE
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   fill_q, fill_d;
    logic                    ptr_q, ptr_d;
    logic                    a_rv_q, a_rv_d;
    logic                    b_rv_q, b_rv_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   din_q, din_d;
    logic                    grant_a, grant_b;
    logic                    ram_we;
    logic [ADDR_WIDTH-1:0]   ram_addr;
    logic [DATA_WIDTH-1:0]   ram_din;

    // State, fill counter, priority pointer, read tags and held RAM bus
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_INIT;
            fill_q  <= '0;
            ptr_q   <= 1'b0;
            a_rv_q  <= 1'b0;
            b_rv_q  <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
            ptr_q   <= ptr_d;
            a_rv_q  <= a_rv_d;
            b_rv_q  <= b_rv_d;
            addr_q  <= addr_d;
            din_q   <= din_d;
        end
    end

    // Next state, grant selection and RAM bus mux
    always_comb begin
        state_d  = state_q;
        fill_d   = fill_q;
        ptr_d    = ptr_q;
        a_rv_d   = 1'b0;
        b_rv_d   = 1'b0;
        grant_a  = 1'b0;
        grant_b  = 1'b0;
        ram_we   = 1'b0;
        ram_addr = addr_q;
        ram_din  = din_q;

        case (state_q)
            ST_INIT: begin
                if (CLEAR_ON_RESET) begin
                    ram_we   = 1'b1;
                    ram_addr = fill_q;
                    ram_din  = '0;
                    fill_d   = fill_q + ADDR_WIDTH'(1);
                    if (fill_q == '1) begin
                        state_d = ST_RUN;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                // Pointer only breaks ties; a lone requester always wins
                grant_a = A_VALID & (~B_VALID | ~ptr_q);
                grant_b = B_VALID & (~A_VALID |  ptr_q);
                if (grant_a) begin
                    ram_we   = A_WE;
                    ram_addr = A_ADDR;
                    ram_din  = A_DIN;
                    ptr_d    = 1'b1;
                    a_rv_d   = ~A_WE;
                end else if (grant_b) begin
                    ram_we   = B_WE;
                    ram_addr = B_ADDR;
                    ram_din  = B_DIN;
                    ptr_d    = 1'b0;
                    b_rv_d   = ~B_WE;
                end
            end
            default: state_d = ST_INIT;
        endcase

        // Reset blocks new grants and RAM writes in the cycle it is asserted
        if (RST) begin
            grant_a = 1'b0;
            grant_b = 1'b0;
            ram_we  = 1'b0;
        end

        addr_d = ram_addr;
        din_d  = ram_din;
    end

    assign A_READY   = grant_a;
    assign B_READY   = grant_b;
    assign RAM_WE    = ram_we;
    assign RAM_ADDR  = ram_addr;
    assign RAM_DIN   = ram_din;
    // A read response still in flight when reset arrives is dropped
    assign A_RVALID  = a_rv_q & ~RST;
    assign B_RVALID  = b_rv_q & ~RST;
    assign A_RDATA   = RAM_DOUT;
    assign B_RDATA   = RAM_DOUT;
    assign INIT_DONE = (state_q == ST_RUN);

endmodule

// File: tb/tb_bram_arbiter.sv
// Directed bench for bram_arbiter: fill sequence, round-robin vector table,
// reset abort of a pending read, and the no-clear variant.
module tb_bram_arbiter;

    localparam int unsigned DW = 5;
    localparam int unsigned AW = 3;

    logic          clk;
    logic          rst, rst2;
    logic          a_valid, a_we, b_valid, b_we;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_din, b_din;
    logic          a_ready, b_ready, a_rvalid, b_rvalid;
    logic [DW-1:0] a_rdata, b_rdata;
    logic          ram_we, init_done;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din, ram_dout;

    logic          a_ready2, b_ready2, a_rvalid2, b_rvalid2, ram_we2, init_done2;
    logic [DW-1:0] a_rdata2, b_rdata2, ram_din2;
    logic [AW-1:0] ram_addr2;
    logic [DW-1:0] ram_dout2;

    logic [DW-1:0] mem [2**AW];

    int n_chk = 0;
    int n_fail = 0;

    bram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_ON_RESET(1'b1)) dut (
        .CLK(clk), .RST(rst),
        .A_VALID(a_valid), .A_READY(a_ready), .A_WE(a_we), .A_ADDR(a_addr), .A_DIN(a_din),
        .A_RVALID(a_rvalid), .A_RDATA(a_rdata),
        .B_VALID(b_valid), .B_READY(b_ready), .B_WE(b_we), .B_ADDR(b_addr), .B_DIN(b_din),
        .B_RVALID(b_rvalid), .B_RDATA(b_rdata),
        .RAM_WE(ram_we), .RAM_ADDR(ram_addr), .RAM_DIN(ram_din), .RAM_DOUT(ram_dout),
        .INIT_DONE(init_done)
    );

    bram_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CLEAR_ON_RESET(1'b0)) dut2 (
        .CLK(clk), .RST(rst2),
        .A_VALID(a_valid), .A_READY(a_ready2), .A_WE(a_we), .A_ADDR(a_addr), .A_DIN(a_din),
        .A_RVALID(a_rvalid2), .A_RDATA(a_rdata2),
        .B_VALID(b_valid), .B_READY(b_ready2), .B_WE(b_we), .B_ADDR(b_addr), .B_DIN(b_din),
        .B_RVALID(b_rvalid2), .B_RDATA(b_rdata2),
        .RAM_WE(ram_we2), .RAM_ADDR(ram_addr2), .RAM_DIN(ram_din2), .RAM_DOUT(ram_dout2),
        .INIT_DONE(init_done2)
    );

    assign ram_dout2 = '0;

    // Single-port RAM with registered read data
    always_ff @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          av, awe;
        logic [AW-1:0] aaddr;
        logic [DW-1:0] adin;
        logic          bv, bwe;
        logic [AW-1:0] baddr;
        logic [DW-1:0] bdin;
        logic          ear, ebr, ewe;
        logic [AW-1:0] eaddr;
        logic [DW-1:0] edin;
        logic          earv, ebrv;
        logic [DW-1:0] erd;
    } vec_t;

    localparam int NV = 14;
    vec_t vecs [NV];

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic set_vec(input int i,
                           input int av, input int awe, input int aaddr, input int adin,
                           input int bv, input int bwe, input int baddr, input int bdin,
                           input int ear, input int ebr, input int ewe, input int eaddr,
                           input int edin, input int earv, input int ebrv, input int erd);
        vecs[i].av    = 1'(av);
        vecs[i].awe   = 1'(awe);
        vecs[i].aaddr = AW'(aaddr);
        vecs[i].adin  = DW'(adin);
        vecs[i].bv    = 1'(bv);
        vecs[i].bwe   = 1'(bwe);
        vecs[i].baddr = AW'(baddr);
        vecs[i].bdin  = DW'(bdin);
        vecs[i].ear   = 1'(ear);
        vecs[i].ebr   = 1'(ebr);
        vecs[i].ewe   = 1'(ewe);
        vecs[i].eaddr = AW'(eaddr);
        vecs[i].edin  = DW'(edin);
        vecs[i].earv  = 1'(earv);
        vecs[i].ebrv  = 1'(ebrv);
        vecs[i].erd   = DW'(erd);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          A: v we ad din   B: v we ad din   exp: ar br we ad din arv brv rd
        set_vec( 0, 1, 1, 5, 'h15,   0, 0, 0, 0,      1, 0, 1, 5, 'h15, 0, 0, 0);
        set_vec( 1, 1, 0, 5, 0,      0, 0, 0, 0,      1, 0, 0, 5, 0,    0, 0, 0);
        set_vec( 2, 0, 0, 0, 0,      0, 0, 0, 0,      0, 0, 0, 5, 0,    1, 0, 'h15);
        set_vec( 3, 1, 0, 5, 0,      1, 0, 3, 0,      0, 1, 0, 3, 0,    0, 0, 0);
        set_vec( 4, 1, 0, 5, 0,      1, 0, 3, 0,      1, 0, 0, 5, 0,    0, 1, 0);
        set_vec( 5, 1, 0, 5, 0,      1, 0, 3, 0,      0, 1, 0, 3, 0,    1, 0, 'h15);
        set_vec( 6, 1, 0, 5, 0,      1, 0, 3, 0,      1, 0, 0, 5, 0,    0, 1, 0);
        set_vec( 7, 0, 0, 0, 0,      0, 0, 0, 0,      0, 0, 0, 5, 0,    1, 0, 'h15);
        set_vec( 8, 1, 1, 7, 'h1f,   1, 1, 2, 'h0a,   0, 1, 1, 2, 'h0a, 0, 0, 0);
        set_vec( 9, 1, 1, 7, 'h1f,   1, 1, 2, 'h0a,   1, 0, 1, 7, 'h1f, 0, 0, 0);
        set_vec(10, 1, 0, 2, 0,      0, 0, 0, 0,      1, 0, 0, 2, 0,    0, 0, 0);
        set_vec(11, 0, 0, 0, 0,      1, 0, 7, 0,      0, 1, 0, 7, 0,    1, 0, 'h0a);
        set_vec(12, 0, 0, 0, 0,      0, 0, 0, 0,      0, 0, 0, 7, 0,    0, 1, 'h1f);
        set_vec(13, 0, 0, 0, 0,      0, 0, 0, 0,      0, 0, 0, 7, 0,    0, 0, 0);

        rst = 1'b1; rst2 = 1'b1;
        a_valid = 1'b0; a_we = 1'b0; a_addr = '0; a_din = '0;
        b_valid = 1'b0; b_we = 1'b0; b_addr = '0; b_din = '0;
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("rst ram_we", int'(ram_we), 0);
        check("rst init_done", int'(init_done), 0);
        check("rst a_rvalid", int'(a_rvalid), 0);

        // Fill: requests held valid to show READY stays low during INIT
        next_cycle();
        rst = 1'b0; rst2 = 1'b0;
        a_valid = 1'b1; b_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check($sformatf("fill%0d ram_we", i), int'(ram_we), 1);
            check($sformatf("fill%0d ram_addr", i), int'(ram_addr), i);
            check($sformatf("fill%0d ram_din", i), int'(ram_din), 0);
            check($sformatf("fill%0d ready", i), int'({a_ready, b_ready}), 0);
            check($sformatf("fill%0d init_done", i), int'(init_done), 0);
            check($sformatf("noclr%0d ram_we", i), int'(ram_we2), 0);
            if (i == 0) begin
                check("noclr c0 init_done", int'(init_done2), 0);
                check("noclr c0 ready", int'({a_ready2, b_ready2}), 0);
            end
            if (i == 1) begin
                check("noclr c1 init_done", int'(init_done2), 1);
                check("noclr c1 ready", int'({a_ready2, b_ready2}), 2);
            end
            next_cycle();
        end
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk);
        check("run init_done", int'(init_done), 1);
        check("run ram_we", int'(ram_we), 0);
        next_cycle();

        for (int i = 0; i < NV; i++) begin
            a_valid = vecs[i].av; a_we = vecs[i].awe; a_addr = vecs[i].aaddr; a_din = vecs[i].adin;
            b_valid = vecs[i].bv; b_we = vecs[i].bwe; b_addr = vecs[i].baddr; b_din = vecs[i].bdin;
            @(negedge clk);
            check($sformatf("v%0d a_ready", i), int'(a_ready), int'(vecs[i].ear));
            check($sformatf("v%0d b_ready", i), int'(b_ready), int'(vecs[i].ebr));
            check($sformatf("v%0d ram_we", i), int'(ram_we), int'(vecs[i].ewe));
            check($sformatf("v%0d ram_addr", i), int'(ram_addr), int'(vecs[i].eaddr));
            check($sformatf("v%0d ram_din", i), int'(ram_din), int'(vecs[i].edin));
            check($sformatf("v%0d a_rvalid", i), int'(a_rvalid), int'(vecs[i].earv));
            check($sformatf("v%0d b_rvalid", i), int'(b_rvalid), int'(vecs[i].ebrv));
            if (vecs[i].earv) check($sformatf("v%0d a_rdata", i), int'(a_rdata), int'(vecs[i].erd));
            if (vecs[i].ebrv) check($sformatf("v%0d b_rdata", i), int'(b_rdata), int'(vecs[i].erd));
            next_cycle();
        end

        // Reset right after a read grant drops the response and restarts fill
        a_valid = 1'b1; a_we = 1'b0; a_addr = 3'd5;
        b_valid = 1'b0;
        @(negedge clk);
        check("abort grant a_ready", int'(a_ready), 1);
        next_cycle();
        a_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check("abort rst a_rvalid", int'(a_rvalid), 0);
        check("abort rst ram_we", int'(ram_we), 0);
        next_cycle();
        rst = 1'b0;
        @(negedge clk);
        check("abort c0 a_rvalid", int'(a_rvalid), 0);
        check("abort c0 ram_we", int'(ram_we), 1);
        check("abort c0 ram_addr", int'(ram_addr), 0);
        check("abort c0 init_done", int'(init_done), 0);
        for (int i = 0; i < 8; i++) next_cycle();
        a_valid = 1'b1; b_valid = 1'b1; b_addr = 3'd1;
        @(negedge clk);
        check("abort run init_done", int'(init_done), 1);
        check("abort ptr a_ready", int'(a_ready), 1);
        check("abort ptr b_ready", int'(b_ready), 0);
        next_cycle();
        a_valid = 1'b0; b_valid = 1'b0;
        @(negedge clk);
        check("abort post a_rvalid", int'(a_rvalid), 1);
        check("abort post a_rdata", int'(a_rdata), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bram_arbiter.md
BRAM_ARBITER -- requirements
Module: bram_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 5: width of the RAM data word.
REQ-002 Parameter ADDR_WIDTH, default 10: width of the RAM address; depth is 2^ADDR_WIDTH.
REQ-003 Parameter CLEAR_ON_RESET, default 1: when 1, the block zero-fills the RAM after reset; when 0, it skips the fill.
REQ-004 CLK  in  1  the single clock; all logic is on the rising edge.
REQ-005 RST  in  1  reset; synchronous and active-high.
REQ-006 A_VALID, B_VALID  in  1  request valid from requester A or B.
REQ-007 A_READY, B_READY  out  1  request accepted this cycle; a transfer occurs when VALID and READY are both high.
REQ-008 A_WE, B_WE  in  1  1 = write request, 0 = read request.
REQ-009 A_ADDR, B_ADDR  in  ADDR_WIDTH  request address.
REQ-010 A_DIN, B_DIN  in  DATA_WIDTH  write data.
REQ-011 A_RVALID, B_RVALID  out  1  read data valid; a one-cycle pulse.
REQ-012 A_RDATA, B_RDATA  out  DATA_WIDTH  read data; meaningful only while the matching RVALID is high.
REQ-013 RAM_WE  out  1  write enable to the shared single-port RAM.
REQ-014 RAM_ADDR  out  ADDR_WIDTH  address to the RAM.
REQ-015 RAM_DIN  out  DATA_WIDTH  write data to the RAM.
REQ-016 RAM_DOUT  in  DATA_WIDTH  RAM read data; registered, valid one cycle after the address.
REQ-017 INIT_DONE  out  1  high once the block is in the RUN state.

Function
REQ-018 The block has two states, INIT and RUN; reset enters INIT.
REQ-019 In INIT, a fill counter drives RAM_ADDR from 0 to 2^ADDR_WIDTH-1, one address per cycle, with RAM_WE=1 and RAM_DIN=0.
REQ-020 The block enters RUN on the cycle after the fill counter writes the last address, so INIT lasts exactly 2^ADDR_WIDTH cycles.
REQ-021 When CLEAR_ON_RESET=0, the block enters RUN on the first cycle after reset is released, and RAM_WE stays 0 throughout INIT.
REQ-022 In INIT, A_READY, B_READY and INIT_DONE are 0.
REQ-023 In RUN, at most one request is granted per cycle; READY is combinational from VALID and the priority pointer.
REQ-024 If only one requester is valid, that requester is granted.
REQ-025 If both requesters are valid, the one selected by the priority pointer is granted; the pointer is 0 for A and 1 for B.
REQ-026 After every grant, the pointer moves to the requester that was not granted, giving strict round-robin.
REQ-027 The pointer does not change in a cycle with no grant.
REQ-028 For a granted request, RAM_WE, RAM_ADDR and RAM_DIN take the granted requester's WE, ADDR and DIN combinationally, in the same cycle.
REQ-029 With no grant in RUN, RAM_WE=0 and RAM_ADDR/RAM_DIN hold their last values.
REQ-030 A granted read pulses the requester's RVALID exactly one cycle after the grant, with RDATA equal to RAM_DOUT in that cycle.
REQ-031 Read latency is fixed at 1; RVALID has no backpressure.
REQ-032 The granted-port/read tag is one register stage.
REQ-033 A granted write produces no RVALID.
REQ-034 Back-to-back grants (one per cycle) are supported; RVALID for grant N and the RAM access for grant N+1 occur in the same cycle.
REQ-035 A read granted in the cycle after a write to the same address returns the newly written data.
REQ-036 The block never asserts A_READY and B_READY in the same cycle.
REQ-037 Reset asserted mid-operation aborts any pending read response: no RVALID is issued for it, and INIT restarts from address 0.

Reset
REQ-038 While RST=1, on the following edge: the state becomes INIT, the fill counter becomes 0, the pointer becomes 0 (A), all RVALID outputs become 0, INIT_DONE becomes 0, and RAM_WE=0.
REQ-039 The fill begins on the first cycle with RST=0.

Verification
REQ-040 Reset, ADDR_WIDTH=3, CLEAR_ON_RESET=1 -> RAM_WE=1 for 8 cycles on addresses 0..7 with DIN=0; then INIT_DONE=1; READY=0 throughout INIT.
REQ-041 RUN, A writes 0x15 to address 5 and B idle; next cycle A reads address 5 -> A_READY=1 on both cycles; A_RVALID=1 one cycle after the read with A_RDATA=0x15; B_RVALID stays 0.
REQ-042 RUN, A and B both valid reads for 4 cycles with pointer=0 -> grants A,B,A,B; RVALIDs alternate A,B,A,B, each lagging its grant by 1 cycle.
REQ-043 Read of an unwritten address after the fill -> RDATA=0.
REQ-044 RST pulsed one cycle after an A read grant -> no A_RVALID; INIT restarts at address 0; pointer is 0.
REQ-045 CLEAR_ON_RESET=0 -> RAM_WE stays 0 after reset; INIT_DONE=1 and READY is available on the second cycle after reset is released.
